// File: rtl/spi1_cmd_target.sv
// SPI1 command target: oversampled SPI frames to single-byte bus requests.
// Optional burst transfers when SPI1_BURST_EN is defined.
module spi1_cmd_target #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                  clk16_i,
  input  logic                  reset_i,
  input  logic                  spi1_sck_i,
  input  logic                  spi1_cs_ni,
  input  logic                  spi1_mcu_tx_i,
  output logic                  spi1_mcu_rx_o,
  output logic                  spi1_mcu_rx_oe,
  output logic                  spi_ready_no,
  output logic                  bus_req_o,
  input  logic                  bus_ack_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [7:0]            bus_data_o,
  output logic                  bus_rw_no,
  input  logic [7:0]            bus_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WR_DATA,
    S_REQ,
    S_RD_OUT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_tx_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic [2:0]            r_bit_cnt;
  logic [6:0]            r_rx_sh;
  logic [7:0]            r_tx_sh;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic                  r_rw_n;
  logic                  r_abort;

  logic       w_sck;
  logic       w_cs_n;
  logic       w_mosi;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_fall;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_cmd_ok;
  logic       w_rd_load;

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '1;
      r_tx_sync  <= '0;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi1_sck_i};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi1_cs_ni};
      r_tx_sync  <= {r_tx_sync[SYNC_STAGES-2:0], spi1_mcu_tx_i};
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs_n;
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_tx_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_d & ~w_cs_n;
  assign w_sck_fall  = ~w_sck & r_sck_d & ~w_cs_n;
  assign w_cs_fall   = ~w_cs_n & r_cs_d;
  assign w_byte      = {r_rx_sh, w_mosi};
  assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_cmd_ok    = ~w_byte[7];

  // Read data is dropped when the frame was abandoned during the request.
  assign w_rd_load = (r_state == S_REQ) & bus_ack_i & r_rw_n
                   & ~r_abort & ~w_cs_n;

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_nx = S_CMD;
      end
      S_CMD: begin
        if (w_byte_done)
          w_state_nx = w_cmd_ok ? S_ADDR_HI : S_DRAIN;
      end
      S_ADDR_HI: begin
        if (w_byte_done) w_state_nx = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        if (w_byte_done)
          w_state_nx = r_rw_n ? S_REQ : S_WR_DATA;
      end
      S_WR_DATA: begin
        if (w_byte_done) w_state_nx = S_REQ;
      end
      S_REQ: begin
        if (bus_ack_i) begin
          if (r_abort || w_cs_n)
            w_state_nx = S_IDLE;
          else if (r_rw_n)
            w_state_nx = S_RD_OUT;
          else
`ifdef SPI1_BURST_EN
            w_state_nx = S_WR_DATA;
`else
            w_state_nx = S_DRAIN;
`endif
        end
      end
      S_RD_OUT: begin
        if (w_byte_done)
`ifdef SPI1_BURST_EN
          w_state_nx = S_REQ;
`else
          w_state_nx = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        w_state_nx = S_DRAIN;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    // A pending bus request must always see its acknowledge.
    if (w_cs_n && (r_state != S_REQ))
      w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      r_bit_cnt <= 3'd0;
      r_rx_sh   <= 7'd0;
      r_tx_sh   <= 8'd0;
      r_addr    <= '0;
      r_wdata   <= 8'd0;
      r_rw_n    <= 1'b1;
      r_abort   <= 1'b0;
    end else begin
      if (w_cs_n)
        r_bit_cnt <= 3'd0;
      else if (w_sck_rise)
        r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_sck_rise)
        r_rx_sh <= w_byte[6:0];

      if (r_state != S_REQ)
        r_abort <= 1'b0;
      else if (w_cs_n)
        r_abort <= 1'b1;

      if (w_byte_done) begin
        if (r_state == S_CMD && w_cmd_ok) begin
          r_rw_n <= w_byte[6];
          r_addr <= ADDR_WIDTH'({w_byte[0], 16'h0000});
        end
        if (r_state == S_ADDR_HI)
          r_addr <= r_addr | ADDR_WIDTH'({w_byte, 8'h00});
        if (r_state == S_ADDR_LO)
          r_addr <= r_addr | ADDR_WIDTH'(w_byte);
        if (r_state == S_WR_DATA)
          r_wdata <= w_byte;
`ifdef SPI1_BURST_EN
        if (r_state == S_RD_OUT)
          r_addr <= r_addr + ADDR_WIDTH'(1);
`endif
      end

`ifdef SPI1_BURST_EN
      if ((r_state == S_REQ) && bus_ack_i && !r_rw_n
          && !r_abort && !w_cs_n)
        r_addr <= r_addr + ADDR_WIDTH'(1);
`endif

      // The fall closing the previous byte (count 0) must not shift.
      if (r_state == S_IDLE && w_cs_fall)
        r_tx_sh <= 8'd0;
      else if (w_rd_load)
        r_tx_sh <= bus_data_i;
      else if ((r_state == S_RD_OUT) && w_sck_fall
               && (r_bit_cnt != 3'd0))
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
    end
  end

  assign bus_req_o      = (r_state == S_REQ);
  assign spi_ready_no   = (r_state == S_REQ);
  assign bus_addr_o     = r_addr;
  assign bus_data_o     = r_wdata;
  assign bus_rw_no      = r_rw_n;
  assign spi1_mcu_rx_oe = ~w_cs_n;
  assign spi1_mcu_rx_o  = ((r_state == S_RD_OUT) || (r_state == S_REQ))
                        & r_tx_sh[7];

endmodule

// File: tb/tb_spi1_cmd_target.sv
// Randomized bench for spi1_cmd_target: MCU driver, bus responder, scoreboard.
// Burst expectations follow SPI1_BURST_EN.
module tb_spi1_cmd_target;

  localparam int AW   = 17;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sck, cs_n, mosi;
  logic          miso, oe, rdy_n, req, ack, rw_n;
  logic [AW-1:0] addr;
  logic [7:0]    wd, rd;

  always #5 clk = ~clk;

  spi1_cmd_target #(.SYNC_STAGES(2), .ADDR_WIDTH(AW)) dut (
    .clk16_i        (clk),
    .reset_i        (rst),
    .spi1_sck_i     (sck),
    .spi1_cs_ni     (cs_n),
    .spi1_mcu_tx_i  (mosi),
    .spi1_mcu_rx_o  (miso),
    .spi1_mcu_rx_oe (oe),
    .spi_ready_no   (rdy_n),
    .bus_req_o      (req),
    .bus_ack_i      (ack),
    .bus_addr_o     (addr),
    .bus_data_o     (wd),
    .bus_rw_no      (rw_n),
    .bus_data_i     (rd)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int            ack_dly    = 2;
  bit            rd_force_en = 1'b0;
  logic [7:0]    rd_force   = 8'h00;
  logic [7:0]    last_rd    = 8'h00;
  int            n_acks     = 0;
  int            stray_req  = 0;
  int            stray_done = 0;
  logic [AW-1:0] rsp_a0;

  logic [AW-1:0] obs_addr[$];
  logic          obs_rw[$];
  logic [7:0]    obs_data[$];
  logic [AW-1:0] exp_addr[$];
  logic          exp_rw[$];
  logic [7:0]    exp_data[$];

  // Bus responder: acks each request after ack_dly cycles.
  initial begin
    ack = 1'b0;
    rd  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && req) begin
        rsp_a0 = addr;
        chk("ready_high", 32'(rdy_n), 32'd1);
        repeat (ack_dly) @(negedge clk);
        chk("addr_stable", 32'(addr), 32'(rsp_a0));
        last_rd = rd_force_en ? rd_force : 8'($urandom);
        rd = last_rd;
        obs_addr.push_back(addr);
        obs_rw.push_back(rw_n);
        obs_data.push_back(rw_n ? last_rd : wd);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_acks++;
        chk("req_drop", 32'(req), 32'd0);
      end else if (stray_req != stray_done) begin
        rd  = 8'hEE;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        stray_done++;
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n,
                          output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      r[i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_assert();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_release();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_acks(input int target, input string tag);
    int t = 0;
    while ((n_acks < target || rdy_n !== 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(n_acks >= target && rdy_n === 1'b0), 32'd1);
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic r,
                          input logic [7:0] d);
    exp_addr.push_back(a);
    exp_rw.push_back(r);
    exp_data.push_back(d);
  endtask

  task automatic compare_txns(input string tag);
    logic [AW-1:0] oa, ea;
    logic          orw, erw;
    logic [7:0]    od, ed;
    chk({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    while (obs_addr.size() > 0 && exp_addr.size() > 0) begin
      oa = obs_addr.pop_front();
      orw = obs_rw.pop_front();
      od = obs_data.pop_front();
      ea = exp_addr.pop_front();
      erw = exp_rw.pop_front();
      ed = exp_data.pop_front();
      chk({tag, "_addr"}, 32'(oa), 32'(ea));
      chk({tag, "_rw"}, 32'(orw), 32'(erw));
      if (!erw) chk({tag, "_data"}, 32'(od), 32'(ed));
    end
    obs_addr.delete(); obs_rw.delete(); obs_data.delete();
    exp_addr.delete(); exp_rw.delete(); exp_data.delete();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    logic [7:0] r;
    int base = n_acks;
    cs_assert();
    spi_bits({7'b0000000, a[16]}, 8, r);
    spi_bits(a[15:8], 8, r);
    spi_bits(a[7:0], 8, r);
    spi_bits(d, 8, r);
    push_exp(a, 1'b0, d);
    wait_acks(base + 1, "wr_ack");
    cs_release();
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [7:0] got,
                         output logic [7:0] expv);
    logic [7:0] r;
    logic [AW-1:0] a1;
    int base = n_acks;
    a1 = a + AW'(1);
    cs_assert();
    spi_bits({7'b0100000, a[16]}, 8, r);
    spi_bits(a[15:8], 8, r);
    spi_bits(a[7:0], 8, r);
    push_exp(a, 1'b1, 8'h00);
    wait_acks(base + 1, "rd_ack");
    expv = last_rd;
    spi_bits(8'h00, 8, got);
`ifdef SPI1_BURST_EN
    push_exp(a1, 1'b1, 8'h00);
    wait_acks(base + 2, "rd_burst_ack");
`endif
    cs_release();
  endtask

  initial begin
    logic [7:0]    got, expv, r;
    logic [AW-1:0] ra;
    logic [7:0]    rdat;
    int            base, t;

    rst  = 1'b1;
    sck  = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data", 32'(wd), 32'd0);
    chk("rst_rw", 32'(rw_n), 32'd1);
    chk("rst_ready", 32'(rdy_n), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed write with A16 set
    do_write(17'h18000, 8'hA5);
    compare_txns("wr1");

    // Directed read with fixed ack latency and data
    ack_dly = 5;
    rd_force_en = 1'b1;
    rd_force = 8'h5A;
    do_read(17'h01234, got, expv);
    chk("rd1_miso", 32'(got), 32'h5A);
    rd_force_en = 1'b0;
    ack_dly = 2;
    compare_txns("rd1");

    // Invalid command
    base = n_acks;
    cs_assert();
    chk("inv_oe", 32'(oe), 32'd1);
    spi_bits(8'hC0, 8, r);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'($urandom), 8, r);
      chk("inv_miso", 32'(r), 32'd0);
    end
    chk("inv_noreq", 32'(n_acks), 32'(base));
    cs_release();
    chk("inv_oe_off", 32'(oe), 32'd0);

    // Stray acknowledge while idle
    stray_req++;
    t = 0;
    while (stray_done != stray_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stray_done", 32'(stray_done), 32'(stray_req));
    repeat (4) @(negedge clk);
    chk("stray_noreq", 32'(req), 32'd0);
    compare_txns("inv");

    // Partial write frame abandoned after 12 bits
    base = n_acks;
    cs_assert();
    spi_bits(8'h00, 8, r);
    spi_bits(8'h00, 4, r);
    cs_release();
    repeat (20) @(negedge clk);
    chk("part_noreq", 32'(n_acks), 32'(base));
    do_write(17'h00010, 8'h33);
    compare_txns("wr2");

    // Chip select released while the read request is pending
    ack_dly = 20;
    base = n_acks;
    cs_assert();
    spi_bits(8'h41, 8, r);
    spi_bits(8'hAB, 8, r);
    spi_bits(8'hCD, 8, r);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_req_held", 32'(req), 32'd1);
    chk("abort_ready_hi", 32'(rdy_n), 32'd1);
    push_exp(17'h1ABCD, 1'b1, 8'h00);
    wait_acks(base + 1, "abort_ack");
    chk("abort_req_low", 32'(req), 32'd0);
    chk("abort_oe", 32'(oe), 32'd0);
    chk("abort_miso", 32'(miso), 32'd0);
    ack_dly = 2;
    repeat (2 * HALF) @(negedge clk);
    compare_txns("abort");
    do_read(17'h0BEEF, got, expv);
    chk("post_abort_miso", 32'(got), 32'(expv));
    compare_txns("post_abort");

    // Extra data bytes after a write: burst or ignored
    base = n_acks;
    cs_assert();
    spi_bits(8'h01, 8, r);
    spi_bits(8'hFF, 8, r);
    spi_bits(8'hFF, 8, r);
    spi_bits(8'h11, 8, r);
    push_exp(17'h1FFFF, 1'b0, 8'h11);
    wait_acks(base + 1, "burst_ack1");
    spi_bits(8'h22, 8, r);
`ifdef SPI1_BURST_EN
    push_exp(17'h00000, 1'b0, 8'h22);
    wait_acks(base + 2, "burst_ack2");
`else
    repeat (20) @(negedge clk);
`endif
    cs_release();
    compare_txns("burst");

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      ack_dly = $urandom_range(0, 10);
      ra = AW'($urandom);
      rdat = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, rdat);
      end else begin
        do_read(ra, got, expv);
        chk("rand_miso", 32'(got), 32'(expv));
      end
      compare_txns("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi1_cmd_target.md
Name: spi1_cmd_target

Overview:
- FPGA-side SPI1 target. Consumes the serial command stream from the MCU on spi1_sck/cs_n/mcu_tx, decodes read/write frames, and issues single-byte requests to the bus arbiter.
- Returns read data to the MCU on spi1_mcu_rx and paces the MCU with spi_ready_no.
- Sits directly between the top-level SPI1 pins and the bus arbiter inside top.
- All SPI inputs are oversampled in the clk16 domain; no SCK-clocked logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck/cs_n/tx; minimum 2.
- ADDR_WIDTH, 17, bus address width; the frame carries A16 in cmd bit 0.

Ports:
- clk16_i  in  1  system clock, 16 MHz.
- reset_i  in  1  asynchronous, active-high reset.
- spi1_sck_i  in  1  SPI clock, mode 0, max clk16_i/4.
- spi1_cs_ni  in  1  active-low chip select; frame boundary.
- spi1_mcu_tx_i  in  1  MOSI, MSB first.
- spi1_mcu_rx_o  out  1  MISO, MSB first.
- spi1_mcu_rx_oe  out  1  MISO output enable; equals !synchronized cs_n.
- spi_ready_no  out  1  low = target idle/ready; high = bus request pending.
- bus_req_o  out  1  request valid; held until bus_ack_i.
- bus_ack_i  in  1  one-cycle acknowledge; transfer done this cycle.
- bus_addr_o  out  ADDR_WIDTH  request address; stable while bus_req_o=1.
- bus_data_o  out  8  write data; stable while bus_req_o=1.
- bus_rw_no  out  1  1=read, 0=write; stable while bus_req_o=1.
- bus_data_i  in  8  read data; valid in the bus_ack_i cycle.

Behaviour:
- Reset values: bus_req_o=0, bus_addr_o=0, bus_data_o=0, bus_rw_no=1, spi_ready_no=0, spi1_mcu_rx_o=0, spi1_mcu_rx_oe=0. State=IDLE.
- Input path: SYNC_STAGES-flop synchronizers, then a one-flop edge detector on sck. Rise = sample MOSI; fall = shift MISO.
- Edge latency: 3 cycles from pin edge to internal strobe at SYNC_STAGES=2.
- Bit counter: 3 bits. Cleared on cs_n falling edge. A byte completes on the 8th rise.
- Frame format, command byte:
  - [7:6]=00: write frame = cmd, addr_hi, addr_lo, data.
  - [7:6]=01: read frame = cmd, addr_hi, addr_lo, dummy.
  - [0]=A16.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, WR_DATA, REQ, RD_OUT, DRAIN.
- Transitions:
  - IDLE: on cs_n fall -> CMD.
  - CMD: byte -> ADDR_HI if command valid, else DRAIN.
  - ADDR_HI: byte -> ADDR_LO.
  - ADDR_LO: byte -> WR_DATA (write) or REQ (read).
  - WR_DATA: byte -> REQ.
  - REQ: assert bus_req_o and spi_ready_no=1. On bus_ack_i -> drop bus_req_o, spi_ready_no=0 next cycle. Read: load bus_data_i into the TX shift register -> RD_OUT. Write: -> DRAIN.
  - RD_OUT: bit 7 is driven on MISO immediately on load; later bits shift on each SCK fall. After 8 rises -> DRAIN.
  - DRAIN: ignore further bytes. MISO=0.
- The MCU must not clock the dummy byte until spi_ready_no=0. Clocking it early is a protocol violation: MISO returns whatever the TX register holds; no error flag.
- cs_n rise (synchronized) from any state -> IDLE, discarding partial bytes and frames. Exception: if in REQ, bus_req_o stays asserted until bus_ack_i. Only then go to IDLE with spi_ready_no=0, and read data is dropped.
- cs_n fall while REQ is still pending is ignored until REQ completes. The MCU must wait for spi_ready_no=0.
- bus_ack_i asserted when bus_req_o=0 is ignored.
- spi1_mcu_rx_oe tracks the synchronized cs_n combinationally, so it is never high while cs_n=1 at the sync output.

Optional Feature:
- Macro: SPI1_BURST_EN.
- Defined:
  - Write frames accept further data bytes after the first. After each write ack, the address increments by 1 modulo 2^ADDR_WIDTH (0x1FFFF -> 0x00000) and the state returns to WR_DATA instead of DRAIN.
  - Read frames: after RD_OUT completes, issue another read at address+1 and hold spi_ready_no=1 until its ack.
- Undefined: single transfer per frame, as above.

Test Plan:
- Write frame 0x01,0x80,0x00,0xA5 -> exactly one bus_req_o with addr=0x18000, rw_n=0, data=0xA5. spi_ready_no pulses high until ack, then low.
- Read frame 0x40,0x12,0x34 with ack 5 cycles later and bus_data_i=0x5A. Dummy byte sent after spi_ready_no=0 -> addr=0x01234, rw_n=1, MISO returns 0x5A.
- Invalid cmd 0xC0 followed by 3 bytes -> no bus_req_o; MISO=0; rx_oe low after cs_n rise.
- cs_n rise after 12 bits of a write frame -> no request. The next write frame 0x00,0x00,0x10,0x33 -> addr=0x00010, data=0x33.
- cs_n rise while REQ is pending with ack delayed 20 cycles -> bus_req_o held, then dropped on ack; spi_ready_no=0; state IDLE.
- With SPI1_BURST_EN: write 0x01,0xFF,0xFF,0x11,0x22 -> writes to 0x1FFFF=0x11, then 0x00000=0x22.
